// File: rtl/bcd_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_display
//  Description : Sequential binary-to-BCD converter feeding a 3-digit,
//                common-anode, multiplexed 7-segment display with blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  val,
    input  logic        val_valid,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state_q;
    logic [7:0]   bin_q;
    logic [11:0]  scratch_q;
    logic [2:0]   cnt_q;
    logic [11:0]  bcd_q;
    logic [11:0]  adj_d;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       digit_q;

    logic [3:0]   nib;
    logic         blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Double-dabble correction applied before each shift
    assign adj_d = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (val_valid) begin
                        bin_q     <= val;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch_q, bin_q} <= {adj_d, bin_q} << 1;
                    cnt_q              <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= scratch_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            digit_q <= 2'd0;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_q   <= '0;
            digit_q <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end else begin
            div_q   <= div_q + DIV_W'(1);
        end
    end

    // Digit select and blanking follow bcd_q directly so a new result shows at once
    always_comb begin
        an    = 3'b110;
        nib   = bcd_q[3:0];
        blank = 1'b0;
        case (digit_q)
            2'd1: begin
                an    = 3'b101;
                nib   = bcd_q[7:4];
                blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            2'd2: begin
                an    = 3'b011;
                nib   = bcd_q[11:8];
                blank = (bcd_q[11:8] == 4'd0);
            end
            default: ;
        endcase

        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        if (blank) begin
            seg = 7'b1111111;
        end
    end

    assign busy = (state_q != IDLE);
    assign bcd  = bcd_q;
    assign dp   = 1'b1;

endmodule
`default_nettype wire
